// File: rtl/lcd_read_controller.sv
// rtl/lcd_read_controller.sv - HD44780-style read cycle engine with single read and busy-flag polling
module lcd_read_controller #(
    parameter int CLK_Divide = 16,
    parameter int SETUP_CYC  = 2,
    parameter int HOLD_CYC   = 2,
    parameter int MAX_POLLS  = 255
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iStart,
    input  logic       iRS,
    input  logic       iPoll,
    input  logic [7:0] LCD_DATA_IN,
    output logic [7:0] oDATA,
    output logic       oDone,
    output logic       oTimeout,
    output logic       oBusy,
    output logic       LCD_EN,
    output logic       LCD_RW,
    output logic       LCD_RS
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [4:0] SETUP_LAST = 5'(SETUP_CYC - 1);
    localparam logic [4:0] EN_LAST    = 5'(CLK_Divide - 1);
    localparam logic [4:0] HOLD_LAST  = 5'(HOLD_CYC - 1);
    localparam logic [7:0] POLL_LIMIT = 8'(MAX_POLLS);

    state_t     state, state_n;
    logic [4:0] cnt, cnt_n;
    logic [7:0] poll_cnt, poll_cnt_n;
    logic       mode, mode_n;
    logic       pre_start;
    logic       start_edge;
    logic [7:0] data_n;
    logic       done_n, timeout_n, busy_n, en_n, rw_n, rs_n;

    assign start_edge = iStart & ~pre_start;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= S_IDLE;
            cnt       <= 5'd0;
            poll_cnt  <= 8'd0;
            mode      <= 1'b0;
            pre_start <= 1'b0;
            oDATA     <= 8'd0;
            oDone     <= 1'b0;
            oTimeout  <= 1'b0;
            oBusy     <= 1'b0;
            LCD_EN    <= 1'b0;
            LCD_RW    <= 1'b0;
            LCD_RS    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            poll_cnt  <= poll_cnt_n;
            mode      <= mode_n;
            pre_start <= iStart;
            oDATA     <= data_n;
            oDone     <= done_n;
            oTimeout  <= timeout_n;
            oBusy     <= busy_n;
            LCD_EN    <= en_n;
            LCD_RW    <= rw_n;
            LCD_RS    <= rs_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        poll_cnt_n = poll_cnt;
        mode_n     = mode;
        data_n     = oDATA;
        done_n     = oDone;
        timeout_n  = oTimeout;
        busy_n     = oBusy;
        en_n       = LCD_EN;
        rw_n       = LCD_RW;
        rs_n       = LCD_RS;

        case (state)
            S_IDLE: begin
                en_n = 1'b0;
                rw_n = 1'b0;
                if (start_edge) begin
                    mode_n     = iPoll;
                    rs_n       = iPoll ? 1'b0 : iRS;
                    done_n     = 1'b0;
                    timeout_n  = 1'b0;
                    busy_n     = 1'b1;
                    rw_n       = 1'b1;
                    poll_cnt_n = 8'd0;
                    cnt_n      = 5'd0;
                    state_n    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_n   = 5'd0;
                    en_n    = 1'b1;
                    state_n = S_STROBE;
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end
            S_STROBE: begin
                if (cnt == EN_LAST) begin
                    cnt_n      = 5'd0;
                    en_n       = 1'b0;
                    data_n     = LCD_DATA_IN;
                    poll_cnt_n = poll_cnt + 8'd1;
                    state_n    = S_HOLD;
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n = 5'd0;
                    // Only a poll that still sees BF set can loop back for another read
                    if (mode && oDATA[7]) begin
                        if (poll_cnt < POLL_LIMIT) begin
                            state_n = S_SETUP;
                        end else begin
                            timeout_n = 1'b1;
                            state_n   = S_DONE;
                        end
                    end else begin
                        state_n = S_DONE;
                    end
                end else begin
                    cnt_n = cnt + 5'd1;
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                rw_n    = 1'b0;
                rs_n    = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/lcd_read_controller.md
Name: lcd_read_controller

Overview:
- Host-side engine that performs HD44780-style read cycles (LCD_RW=1): single data/register reads, or busy-flag polling.
- Companion to the write-only LCD controller. Both share the LCD_EN/LCD_RS/LCD_RW pins through an external mux selected by oBusy.
- The host starts a read with a rising edge on iStart and gets the byte on oDATA, qualified by level oDone.
- Poll mode repeats status reads until BF (bit 7) clears or a poll limit is reached.

Parameters:
- CLK_Divide, 16, LCD_EN high width in iCLK cycles (1..31).
- SETUP_CYC, 2, cycles RS/RW are stable before the LCD_EN rise (1..15).
- HOLD_CYC, 2, cycles RW is held high after the LCD_EN fall (1..15).
- MAX_POLLS, 255, maximum status reads in poll mode (1..255).

Ports:
- iCLK  in  1  clock.
- iRST_N  in  1  reset, asynchronous, active-low.
- iStart  in  1  start request; rising edge triggers one transaction.
- iRS  in  1  register select for a single read (0 = status/address, 1 = data RAM); ignored when iPoll=1.
- iPoll  in  1  1 = busy-poll mode.
- LCD_DATA_IN  in  8  LCD data bus as seen by the host (external tri-state).
- oDATA  out  8  last byte read.
- oDone  out  1  transaction complete; level, held until the next accepted start.
- oTimeout  out  1  poll ended with BF still 1.
- oBusy  out  1  transaction in progress; grants the shared LCD pins.
- LCD_EN  out  1  LCD enable strobe.
- LCD_RW  out  1  1 = read. When 1, the host bus driver must be tri-stated.
- LCD_RS  out  1  LCD register select.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-cycle): oDATA=0, oDone=0, oTimeout=0, oBusy=0, LCD_EN=0, LCD_RW=0, LCD_RS=0. State=IDLE, counters=0, preStart=0.
- Start detect:
  - preStart is registered from iStart every cycle.
  - Edge when {preStart,iStart}==2'b01 at a clock edge T.
  - Accepted only in IDLE; edges while oBusy=1 are ignored (no queueing).
- On acceptance at edge T:
  - Latch mode := iPoll and rs := iPoll ? 0 : iRS.
  - oDone<=0, oTimeout<=0, oBusy<=1, LCD_RW<=1, LCD_RS<=rs, poll count<=0.
  - State<=SETUP.
- States:
  - IDLE: outputs hold. LCD_RW=0, LCD_EN=0.
  - SETUP: count SETUP_CYC cycles with LCD_EN=0. LCD_EN rises at edge T+SETUP_CYC; go to STROBE.
  - STROBE: LCD_EN=1 for exactly CLK_Divide cycles. At edge T+SETUP_CYC+CLK_Divide: LCD_EN<=0, oDATA<=LCD_DATA_IN, count<=count+1; go to HOLD.
  - HOLD: LCD_RW stays 1 for HOLD_CYC cycles, then decide:
    - Single mode → DONE.
    - Poll mode and oDATA[7]=0 → DONE.
    - Poll mode, oDATA[7]=1, count<MAX_POLLS → SETUP (new read, same timing).
    - Poll mode, oDATA[7]=1, count==MAX_POLLS → DONE with oTimeout<=1.
  - DONE (single edge): oDone<=1, oBusy<=0, LCD_RW<=0, LCD_RS<=0; go to IDLE.
- Latency, single read: oDone rises at edge T+SETUP_CYC+CLK_Divide+HOLD_CYC+1. Defaults give T+21.
- Poll: each additional read adds SETUP_CYC+CLK_Divide+HOLD_CYC cycles (20 with defaults).
- oDATA changes only at LCD_EN falling edges; it is stable while oDone=1.
- LCD_RS and LCD_RW never change while LCD_EN=1.
- LCD_EN is never high outside STROBE.
- Counters are 5 bits (EN/setup/hold) and 8 bits (poll). No wrap is possible within the parameter ranges.
- iStart held high produces exactly one transaction.
- iStart rising in the same cycle as DONE is ignored: state is not yet IDLE.

Test Plan:
- Single data read: iRS=1, iPoll=0, LCD_DATA_IN=8'hA5, pulse iStart at edge T → LCD_RW=1 and LCD_RS=1 from T. LCD_EN high edges T+2..T+18. oDATA=8'hA5 and oDone=1 at T+21. LCD_RW=0 afterwards.
- Status read: iRS=0, LCD_DATA_IN=8'h3C → LCD_RS=0, oDATA=8'h3C, oTimeout=0, single EN pulse.
- Poll until ready: iPoll=1, LCD_DATA_IN=8'h80 for the first 3 strobes then 8'h05 → exactly 4 EN pulses, LCD_RS=0 throughout. oDATA=8'h05, oDone=1, oTimeout=0 at T+1+4×20.
- Poll timeout: MAX_POLLS=3, LCD_DATA_IN=8'hFF constant → 3 EN pulses, oDone=1, oTimeout=1, oDATA=8'hFF.
- Busy rejection and level start: second iStart rising edge mid-STROBE, and iStart held high for 100 cycles → exactly one transaction each. oDone stays 0 until the first transaction completes.
- Reset mid-strobe: assert iRST_N=0 while LCD_EN=1 → LCD_EN, LCD_RW, oBusy, oDone and oDATA go 0 immediately. After release, a new iStart edge runs a full clean transaction.
